// File: rtl/ctrl_unit_pipe_pkg.sv
// Shared decode constants and the control bundle type. The decoder and the EX stage both import
// this package, so they always agree on field encodings.
package ctrl_unit_pipe_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  localparam logic [31:0] INST_ECALL = 32'h0000_0073;
  localparam logic [31:0] INST_MRET  = 32'h3020_0073;

  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_SLL  = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4;
  localparam logic [3:0] ALU_SLTU = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_OR   = 4'd9;
  localparam logic [3:0] ALU_AND  = 4'd10;
  localparam logic [3:0] ALU_AOUT = 4'd11;
  localparam logic [3:0] ALU_BOUT = 4'd12;

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_B    = 3'd2;
  localparam logic [2:0] IMM_J    = 3'd3;
  localparam logic [2:0] IMM_S    = 3'd4;
  localparam logic [2:0] IMM_U    = 3'd5;

  localparam logic [2:0] CMP_NONE = 3'd0;
  localparam logic [2:0] CMP_EQ   = 3'd1;
  localparam logic [2:0] CMP_NE   = 3'd2;
  localparam logic [2:0] CMP_LT   = 3'd3;
  localparam logic [2:0] CMP_LTU  = 3'd4;
  localparam logic [2:0] CMP_GE   = 3'd5;
  localparam logic [2:0] CMP_GEU  = 3'd6;

  localparam logic [1:0] HAZ_NONE  = 2'd0;
  localparam logic [1:0] HAZ_ALU   = 2'd1;
  localparam logic [1:0] HAZ_LOAD  = 2'd2;
  localparam logic [1:0] HAZ_STORE = 2'd3;

  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic [2:0] imm_sel;
    logic [2:0] cmp_ctrl;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       reg_write;
    logic       mem_r;
    logic       mem_w;
    logic       data_to_reg;
    logic       jal;
    logic       jalr;
    logic       mret;
    logic       csr_rw;
    logic       csr_imm;
    logic       rs1use;
    logic       rs2use;
    logic [1:0] hazard_optype;
    logic [4:0] rd;
    logic       md_start;
    logic [2:0] md_op;
    logic [1:0] exp_vector;
  } ctrl_bundle_t;

  // alt selects SUB/SRA where funct7 bit 5 is set
  function automatic logic [3:0] alu_op_from_funct3(input logic [2:0] funct3, input logic alt);
    logic [3:0] op;
    op = ALU_NONE;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic [5:0] md_latency(input logic [2:0] funct3, input logic [5:0] mul_lat,
                                            input logic [5:0] div_lat);
    return funct3[2] ? div_lat : mul_lat;
  endfunction

endpackage

// File: rtl/ctrl_unit_pipe_if.sv
// IF/ID -> control -> ID/EX handshake and control bundle. The slave side is the control unit;
// the master side is the surrounding pipeline.
interface ctrl_unit_pipe_if;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_ctrl;
  logic [2:0]  imm_sel;
  logic [2:0]  cmp_ctrl;
  logic        alu_src_a;
  logic        alu_src_b;
  logic        reg_write;
  logic        mem_r;
  logic        mem_w;
  logic        data_to_reg;
  logic        jal;
  logic        jalr;
  logic        mret;
  logic        csr_rw;
  logic        csr_imm;
  logic        rs1use;
  logic        rs2use;
  logic [1:0]  hazard_optype;
  logic [4:0]  rd;
  logic        md_start;
  logic [2:0]  md_op;
  logic        md_busy;
  logic [1:0]  exp_vector;

  modport master (
    output flush, in_valid, in_inst, out_ready,
    input  in_ready, out_valid, alu_ctrl, imm_sel, cmp_ctrl, alu_src_a, alu_src_b, reg_write,
           mem_r, mem_w, data_to_reg, jal, jalr, mret, csr_rw, csr_imm, rs1use, rs2use,
           hazard_optype, rd, md_start, md_op, md_busy, exp_vector
  );

  modport slave (
    input  flush, in_valid, in_inst, out_ready,
    output in_ready, out_valid, alu_ctrl, imm_sel, cmp_ctrl, alu_src_a, alu_src_b, reg_write,
           mem_r, mem_w, data_to_reg, jal, jalr, mret, csr_rw, csr_imm, rs1use, rs2use,
           hazard_optype, rd, md_start, md_op, md_busy, exp_vector
  );
endinterface

// File: rtl/ctrl_unit_pipe_inst_decoder.sv
// Combinational RV32I + Zicsr + MRET/ECALL decoder, with optional RV32M.
// Illegal encodings and ECALL produce an all-zero bundle apart from rd and exp_vector.
module ctrl_unit_pipe_inst_decoder
  import ctrl_unit_pipe_pkg::*;
#(
  parameter int unsigned EN_M = 1
) (
  input  logic [31:0]  inst,
  output ctrl_bundle_t ctrl,
  output logic         inst_is_m
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  ctrl_bundle_t dec;
  logic illegal;
  logic ecall;
  logic is_m;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  always_comb begin
    dec     = '0;
    illegal = 1'b0;
    ecall   = 1'b0;
    is_m    = 1'b0;
    dec.rd  = inst[11:7];
    case (opcode)
      OPC_LUI: begin
        dec.imm_sel = IMM_U;  dec.alu_ctrl = ALU_BOUT;  dec.alu_src_b = 1'b1;
        dec.reg_write = 1'b1; dec.hazard_optype = HAZ_ALU;
      end
      OPC_AUIPC: begin
        dec.imm_sel = IMM_U;  dec.alu_ctrl = ALU_ADD;   dec.alu_src_a = 1'b1;
        dec.alu_src_b = 1'b1; dec.reg_write = 1'b1;    dec.hazard_optype = HAZ_ALU;
      end
      OPC_JAL: begin
        dec.imm_sel = IMM_J;  dec.alu_ctrl = ALU_ADD;   dec.alu_src_a = 1'b1;
        dec.alu_src_b = 1'b1; dec.jal = 1'b1;           dec.reg_write = 1'b1;
        dec.hazard_optype = HAZ_ALU;
      end
      OPC_JALR: begin
        if (funct3 != 3'b000) illegal = 1'b1;
        dec.imm_sel = IMM_I;  dec.alu_ctrl = ALU_ADD;   dec.alu_src_b = 1'b1;
        dec.jalr = 1'b1;      dec.reg_write = 1'b1;     dec.rs1use = 1'b1;
        dec.hazard_optype = HAZ_ALU;
      end
      OPC_BRANCH: begin
        dec.imm_sel = IMM_B;  dec.alu_ctrl = ALU_ADD;   dec.alu_src_a = 1'b1;
        dec.alu_src_b = 1'b1; dec.rs1use = 1'b1;        dec.rs2use = 1'b1;
        case (funct3)
          3'b000:  dec.cmp_ctrl = CMP_EQ;
          3'b001:  dec.cmp_ctrl = CMP_NE;
          3'b100:  dec.cmp_ctrl = CMP_LT;
          3'b101:  dec.cmp_ctrl = CMP_GE;
          3'b110:  dec.cmp_ctrl = CMP_LTU;
          3'b111:  dec.cmp_ctrl = CMP_GEU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) illegal = 1'b1;
        dec.imm_sel = IMM_I;  dec.alu_ctrl = ALU_ADD;   dec.alu_src_b = 1'b1;
        dec.mem_r = 1'b1;     dec.data_to_reg = 1'b1;   dec.reg_write = 1'b1;
        dec.rs1use = 1'b1;    dec.hazard_optype = HAZ_LOAD;
      end
      OPC_STORE: begin
        if (funct3[2] || funct3 == 3'b011) illegal = 1'b1;
        dec.imm_sel = IMM_S;  dec.alu_ctrl = ALU_ADD;   dec.alu_src_b = 1'b1;
        dec.mem_w = 1'b1;     dec.rs1use = 1'b1;        dec.rs2use = 1'b1;
        dec.hazard_optype = HAZ_STORE;
      end
      OPC_OP_IMM: begin
        dec.imm_sel = IMM_I;  dec.alu_src_b = 1'b1;     dec.reg_write = 1'b1;
        dec.rs1use = 1'b1;    dec.hazard_optype = HAZ_ALU;
        dec.alu_ctrl = alu_op_from_funct3(funct3, 1'b0);
        if (funct3 == 3'b001 && funct7 != F7_BASE) illegal = 1'b1;
        if (funct3 == 3'b101) begin
          if (funct7 == F7_ALT) dec.alu_ctrl = ALU_SRA;
          else if (funct7 != F7_BASE) illegal = 1'b1;
        end
      end
      OPC_OP: begin
        dec.reg_write = 1'b1; dec.rs1use = 1'b1;        dec.rs2use = 1'b1;
        dec.hazard_optype = HAZ_ALU;
        if (funct7 == F7_MULDIV) begin
          // Result comes back late from the MDU, so EX treats it like a load
          if (EN_M != 0) begin
            is_m = 1'b1;          dec.md_start = 1'b1;  dec.md_op = funct3;
            dec.alu_ctrl = ALU_NONE;  dec.hazard_optype = HAZ_LOAD;
          end else begin
            illegal = 1'b1;
          end
        end else if (funct7 == F7_BASE) begin
          dec.alu_ctrl = alu_op_from_funct3(funct3, 1'b0);
        end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          dec.alu_ctrl = alu_op_from_funct3(funct3, 1'b1);
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_FENCE: ;
      OPC_SYSTEM: begin
        case (funct3)
          3'b000: begin
            if (inst == INST_ECALL) ecall = 1'b1;
            else if (inst == INST_MRET) dec.mret = 1'b1;
            else illegal = 1'b1;
          end
          3'b001, 3'b010, 3'b011: begin
            dec.csr_rw = 1'b1;    dec.reg_write = 1'b1;   dec.rs1use = 1'b1;
            dec.hazard_optype = HAZ_ALU;
          end
          3'b101, 3'b110, 3'b111: begin
            dec.csr_rw = 1'b1;    dec.csr_imm = 1'b1;     dec.reg_write = 1'b1;
            dec.hazard_optype = HAZ_ALU;
          end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    ctrl = dec;
    if (illegal || ecall) begin
      ctrl            = '0;
      ctrl.rd         = inst[11:7];
      ctrl.exp_vector = {illegal, ecall};
    end
  end

  assign inst_is_m = is_m & ~illegal;

endmodule

// File: rtl/ctrl_unit_pipe.sv
// Registered control unit between IF/ID and ID/EX. Holds one decoded bundle and tracks a single
// in-flight MUL/DIV, stalling M-ops and dependent instructions until its latency expires.
module ctrl_unit_pipe
  import ctrl_unit_pipe_pkg::*;
#(
  parameter int unsigned EN_M    = 1,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 33
) (
  input logic              clk,
  input logic              rst,
  ctrl_unit_pipe_if.slave  bus
);

  localparam logic [5:0] MulLat = MUL_LAT[5:0];
  localparam logic [5:0] DivLat = DIV_LAT[5:0];

  ctrl_bundle_t dec;
  ctrl_bundle_t bundle_q;
  logic         inst_is_m;
  logic         out_valid_q;
  logic [5:0]   md_cnt_q;
  logic [4:0]   md_rd_q;
  logic         md_rd_vld_q;
  logic         md_busy;
  logic         dep_hit;
  logic         stall;
  logic         in_ready;
  logic         accept;

  ctrl_unit_pipe_inst_decoder #(
    .EN_M(EN_M)
  ) u_inst_decoder (
    .inst      (bus.in_inst),
    .ctrl      (dec),
    .inst_is_m (inst_is_m)
  );

  assign md_busy = (md_cnt_q != 6'd0);
  assign dep_hit = (dec.rs1use    && bus.in_inst[19:15] == md_rd_q) ||
                   (dec.rs2use    && bus.in_inst[24:20] == md_rd_q) ||
                   (dec.reg_write && dec.rd == md_rd_q);
  assign stall    = md_busy & (inst_is_m | (md_rd_vld_q & dep_hit));
  assign in_ready = (~out_valid_q | bus.out_ready) & ~stall & ~bus.flush;
  assign accept   = bus.in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
      md_cnt_q    <= 6'd0;
      md_rd_q     <= 5'd0;
      md_rd_vld_q <= 1'b0;
    end else begin
      if (md_busy) begin
        md_cnt_q <= md_cnt_q - 6'd1;
        if (md_cnt_q == 6'd1) md_rd_vld_q <= 1'b0;
      end
      if (bus.flush) begin
        out_valid_q <= 1'b0;
        // A killed M-op never reaches the MDU; one already consumed keeps counting
        if (out_valid_q && bundle_q.md_start) begin
          md_cnt_q    <= 6'd0;
          md_rd_vld_q <= 1'b0;
        end
      end else if (accept) begin
        bundle_q    <= dec;
        out_valid_q <= 1'b1;
        if (inst_is_m) begin
          md_cnt_q    <= md_latency(dec.md_op, MulLat, DivLat);
          md_rd_q     <= dec.rd;
          md_rd_vld_q <= (dec.rd != 5'd0);
        end
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid_q;
  assign bus.alu_ctrl      = bundle_q.alu_ctrl;
  assign bus.imm_sel       = bundle_q.imm_sel;
  assign bus.cmp_ctrl      = bundle_q.cmp_ctrl;
  assign bus.alu_src_a     = bundle_q.alu_src_a;
  assign bus.alu_src_b     = bundle_q.alu_src_b;
  assign bus.reg_write     = bundle_q.reg_write;
  assign bus.mem_r         = bundle_q.mem_r;
  assign bus.mem_w         = bundle_q.mem_w;
  assign bus.data_to_reg   = bundle_q.data_to_reg;
  assign bus.jal           = bundle_q.jal;
  assign bus.jalr          = bundle_q.jalr;
  assign bus.mret          = bundle_q.mret;
  assign bus.csr_rw        = bundle_q.csr_rw;
  assign bus.csr_imm       = bundle_q.csr_imm;
  assign bus.rs1use        = bundle_q.rs1use;
  assign bus.rs2use        = bundle_q.rs2use;
  assign bus.hazard_optype = bundle_q.hazard_optype;
  assign bus.rd            = bundle_q.rd;
  assign bus.md_start      = bundle_q.md_start;
  assign bus.md_op         = bundle_q.md_op;
  assign bus.md_busy       = md_busy;
  assign bus.exp_vector    = bundle_q.exp_vector;

endmodule

// File: tb/tb_ctrl_unit_pipe.sv
// Directed bench for ctrl_unit_pipe: one DUT with RV32M enabled, one with it disabled.
module tb_ctrl_unit_pipe;

  localparam logic [31:0] I_ADD3  = 32'h0020_81B3;  // add x3,x1,x2
  localparam logic [31:0] I_MUL5  = 32'h0220_82B3;  // mul x5,x1,x2
  localparam logic [31:0] I_ADD6  = 32'h0012_8333;  // add x6,x5,x1
  localparam logic [31:0] I_DIV7  = 32'h0220_C3B3;  // div x7,x1,x2
  localparam logic [31:0] I_ADD8  = 32'h0020_8433;  // add x8,x1,x2
  localparam logic [31:0] I_ECALL = 32'h0000_0073;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  ctrl_unit_pipe_if bus ();
  ctrl_unit_pipe_if bus_nm ();

  ctrl_unit_pipe #(.EN_M(1), .MUL_LAT(3), .DIV_LAT(33)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ctrl_unit_pipe #(.EN_M(0), .MUL_LAT(3), .DIV_LAT(33)) dut_nm (
    .clk (clk),
    .rst (rst),
    .bus (bus_nm)
  );

  always #5 clk = ~clk;

  // Decode table: {imm_sel, cmp_ctrl, reg_write, mem_r, mem_w, rs1use, rs2use, csr_imm, mret}
  logic [31:0] dec_inst [7] = '{32'h0081_2203, 32'h0020_9463, 32'h3002_D0F3, 32'h3020_0073,
                                32'h0020_A223, 32'h1234_52B7, 32'h0000_00EF};
  logic [12:0] dec_exp  [7] = '{{3'd1, 3'd0, 7'b1101000}, {3'd2, 3'd2, 7'b0001100},
                                {3'd0, 3'd0, 7'b1000010}, {3'd0, 3'd0, 7'b0000001},
                                {3'd4, 3'd0, 7'b0011100}, {3'd5, 3'd0, 7'b1000000},
                                {3'd3, 3'd0, 7'b1000000}};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [35:0] fields;
    rst = 1'b1;
    bus.flush = 1'b0;    bus.in_valid = 1'b1;    bus.in_inst = I_ADD3;    bus.out_ready = 1'b1;
    bus_nm.flush = 1'b0; bus_nm.in_valid = 1'b0; bus_nm.in_inst = 32'h0; bus_nm.out_ready = 1'b1;
    tick();
    tick();
    fields = {bus.alu_ctrl, bus.imm_sel, bus.cmp_ctrl, bus.alu_src_a, bus.alu_src_b,
              bus.reg_write, bus.mem_r, bus.mem_w, bus.data_to_reg, bus.jal, bus.jalr, bus.mret,
              bus.csr_rw, bus.csr_imm, bus.rs1use, bus.rs2use, bus.hazard_optype, bus.rd,
              bus.md_start, bus.md_op, bus.exp_vector};
    n_total++;
    if ({bus.out_valid, bus.md_busy} !== 2'b00)
      $display("FAIL reset_valid_busy: got %b required 00", {bus.out_valid, bus.md_busy});
    else n_pass++;
    n_total++;
    if (fields !== 36'd0) $display("FAIL reset_fields: got %h required 0", fields);
    else n_pass++;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    n_total++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10)
      $display("FAIL reset_release: got in_ready,out_valid=%b required 10",
               {bus.in_ready, bus.out_valid});
    else n_pass++;
  endtask

  task automatic test_add();
    bus.in_inst = I_ADD3;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_total++;
    if ({bus.out_valid, bus.alu_ctrl, bus.reg_write, bus.rd, bus.hazard_optype, bus.md_start}
        !== {1'b1, 4'd1, 1'b1, 5'd3, 2'd1, 1'b0})
      $display("FAIL add_bundle: got v=%b alu=%0d rw=%b rd=%0d haz=%0d md=%b required 1 1 1 3 1 0",
               bus.out_valid, bus.alu_ctrl, bus.reg_write, bus.rd, bus.hazard_optype,
               bus.md_start);
    else n_pass++;
    tick();
    n_total++;
    if (bus.out_valid !== 1'b0) $display("FAIL add_drain: got out_valid=%b required 0", bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_decode();
    logic [12:0] got;
    for (int i = 0; i < 7; i++) begin
      bus.in_inst = dec_inst[i];
      bus.in_valid = 1'b1;
      tick();
      got = {bus.imm_sel, bus.cmp_ctrl, bus.reg_write, bus.mem_r, bus.mem_w, bus.rs1use,
             bus.rs2use, bus.csr_imm, bus.mret};
      n_total++;
      if (bus.out_valid !== 1'b1 || got !== dec_exp[i])
        $display("FAIL decode_%0d: inst=%h got v=%b fields=%b required v=1 fields=%b",
                 i, dec_inst[i], bus.out_valid, got, dec_exp[i]);
      else n_pass++;
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_mul_dep();
    int stalled;
    bus.in_inst = I_MUL5;
    bus.in_valid = 1'b1;
    tick();
    bus.in_inst = I_ADD6;
    n_total++;
    if ({bus.out_valid, bus.md_start, bus.md_busy, bus.reg_write, bus.data_to_reg,
         bus.hazard_optype, bus.alu_ctrl} !== {5'b11110, 2'd2, 4'd0})
      $display("FAIL mul_bundle: got v,start,busy,rw,d2r=%b haz=%0d alu=%0d required 11110 2 0",
               {bus.out_valid, bus.md_start, bus.md_busy, bus.reg_write, bus.data_to_reg},
               bus.hazard_optype, bus.alu_ctrl);
    else n_pass++;
    #1;
    stalled = 0;
    while (bus.in_ready !== 1'b1 && stalled < 100) begin
      stalled++;
      tick();
    end
    n_total++;
    if (stalled !== 3) $display("FAIL mul_dep_stall: got %0d cycles required 3", stalled);
    else n_pass++;
    tick();
    bus.in_valid = 1'b0;
    n_total++;
    if ({bus.out_valid, bus.rd, bus.md_start} !== {1'b1, 5'd6, 1'b0})
      $display("FAIL mul_dep_issue: got v=%b rd=%0d md=%b required 1 6 0",
               bus.out_valid, bus.rd, bus.md_start);
    else n_pass++;
    tick();
  endtask

  task automatic test_div_indep();
    int stalled;
    bus.in_inst = I_DIV7;
    bus.in_valid = 1'b1;
    tick();
    bus.in_inst = I_ADD8;
    #1;
    n_total++;
    if (bus.in_ready !== 1'b1) $display("FAIL div_indep_ready: got %b required 1", bus.in_ready);
    else n_pass++;
    tick();
    n_total++;
    if ({bus.out_valid, bus.rd, bus.md_busy} !== {1'b1, 5'd8, 1'b1})
      $display("FAIL div_indep_issue: got v=%b rd=%0d busy=%b required 1 8 1",
               bus.out_valid, bus.rd, bus.md_busy);
    else n_pass++;
    bus.in_inst = I_DIV7;
    #1;
    stalled = 0;
    while (bus.in_ready !== 1'b1 && stalled < 100) begin
      stalled++;
      tick();
    end
    // One of the 33 busy cycles was spent issuing the add
    n_total++;
    if (stalled !== 32) $display("FAIL div_div_stall: got %0d cycles required 32", stalled);
    else n_pass++;
    tick();
    bus.in_valid = 1'b0;
    n_total++;
    if ({bus.out_valid, bus.md_start, bus.md_op, bus.md_busy} !== {2'b11, 3'd4, 1'b1})
      $display("FAIL div2_issue: got v=%b start=%b op=%0d busy=%b required 1 1 4 1",
               bus.out_valid, bus.md_start, bus.md_op, bus.md_busy);
    else n_pass++;
    for (int i = 0; i < 32; i++) tick();
    n_total++;
    if (bus.md_busy !== 1'b1) $display("FAIL div_busy_last: got %b required 1", bus.md_busy);
    else n_pass++;
    tick();
    n_total++;
    if (bus.md_busy !== 1'b0) $display("FAIL div_busy_done: got %b required 0", bus.md_busy);
    else n_pass++;
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    bus.in_inst = I_MUL5;
    bus.in_valid = 1'b1;
    tick();
    bus.in_inst = I_ADD8;
    #1;
    n_total++;
    if (bus.in_ready !== 1'b0) $display("FAIL hold_ready: got %b required 0", bus.in_ready);
    else n_pass++;
    tick();
    n_total++;
    if ({bus.out_valid, bus.md_start, bus.md_busy} !== 3'b111)
      $display("FAIL hold_bundle: got %b required 111",
               {bus.out_valid, bus.md_start, bus.md_busy});
    else n_pass++;
    bus.in_valid = 1'b0;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    n_total++;
    if ({bus.out_valid, bus.md_busy} !== 2'b00)
      $display("FAIL flush_kill: got v,busy=%b required 00", {bus.out_valid, bus.md_busy});
    else n_pass++;
    bus.out_ready = 1'b1;
    bus.in_inst = I_ADD6;
    bus.in_valid = 1'b1;
    #1;
    n_total++;
    if (bus.in_ready !== 1'b1) $display("FAIL flush_nostall: got %b required 1", bus.in_ready);
    else n_pass++;
    tick();
    bus.in_valid = 1'b0;
    n_total++;
    if ({bus.out_valid, bus.rd} !== {1'b1, 5'd6})
      $display("FAIL flush_issue: got v=%b rd=%0d required 1 6", bus.out_valid, bus.rd);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.in_inst = I_DIV7;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    bus.flush = 1'b1;
    tick();
    rst = 1'b0;
    bus.flush = 1'b0;
    n_total++;
    if ({bus.out_valid, bus.md_busy} !== 2'b00)
      $display("FAIL reset_mid: got v,busy=%b required 00", {bus.out_valid, bus.md_busy});
    else n_pass++;
    bus.in_inst = I_MUL5;
    bus.in_valid = 1'b1;
    #1;
    n_total++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_mid_ready: got %b required 1", bus.in_ready);
    else n_pass++;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_no_m();
    bus_nm.in_inst = I_MUL5;
    bus_nm.in_valid = 1'b1;
    tick();
    n_total++;
    if ({bus_nm.out_valid, bus_nm.exp_vector, bus_nm.reg_write, bus_nm.md_start, bus_nm.md_busy}
        !== 6'b110000)
      $display("FAIL nom_illegal: got v=%b exp=%b rw=%b start=%b busy=%b required 1 10 0 0 0",
               bus_nm.out_valid, bus_nm.exp_vector, bus_nm.reg_write, bus_nm.md_start,
               bus_nm.md_busy);
    else n_pass++;
    bus_nm.in_inst = I_ECALL;
    tick();
    bus_nm.in_valid = 1'b0;
    n_total++;
    if ({bus_nm.out_valid, bus_nm.exp_vector, bus_nm.reg_write, bus_nm.csr_rw} !== 5'b10100)
      $display("FAIL nom_ecall: got v=%b exp=%b rw=%b csr=%b required 1 01 0 0",
               bus_nm.out_valid, bus_nm.exp_vector, bus_nm.reg_write, bus_nm.csr_rw);
    else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_decode();
    test_mul_dep();
    test_div_indep();
    test_flush();
    test_reset_mid();
    test_no_m();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

endmodule
